branch_resolve_unit: RTL

//  ID-stage branch resolution for the 5-stage MIPS pipeline: forwards rs/rt operands from EX/MEM or MEM/WB,

---
 rtl/branch_resolve_unit_pkg.sv | 18 +
 rtl/branch_resolve_unit_fwd_mux.sv | 41 ++++
 rtl/branch_resolve_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_unit_pkg: shared forwarding-select codes and FSM encodings    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package branch_resolve_unit_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_fwd_mux: forwarding-source select and 3:1 operand mux for one source  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module branch_fwd_mux
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exmem_regwrite,
  input  logic              exmem_memread,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] data
);

  // A load in EX/MEM has no data yet, so it must fall through to the older MEM/WB source.
  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (src != '0) begin
      if (exmem_regwrite && !exmem_memread && (exmem_rd == src)) begin
        sel  = FWD_EXMEM;
        data = exmem_data;
      end else if (memwb_regwrite && (memwb_rd == src)) begin
        sel  = FWD_MEMWB;
        data = memwb_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_unit: ID-stage beq/bne resolution with forwarding, hazard     |
// | stalls and saturating perf counters.                          Rev 1.0        |
// +----------------------------------------------------------------------------+
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_is_beq,
  input  logic              id_is_bne,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] rf_rs,
  input  logic [DATA_W-1:0] rf_rt,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              exmem_regwrite,
  input  logic              exmem_memread,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              stall,
  output logic              branch_taken,
  output logic              if_flush,
  output logic [1:0]        fwd_sel_rs,
  output logic [1:0]        fwd_sel_rt,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_taken,
  output logic [CNT_W-1:0]  cnt_stall
);

  logic [1:0]        sel_rs, sel_rt;
  logic [DATA_W-1:0] op_a, op_b;

  branch_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src(id_rs), .rf_data(rf_rs),
    .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .sel(sel_rs), .data(op_a)
  );

  branch_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src(id_rt), .rf_data(rf_rt),
    .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .sel(sel_rt), .data(op_b)
  );

  // Cycles a source must wait before a forwarding path can supply it.
  function automatic logic [1:0] src_need(input logic [REG_AW-1:0] src);
    logic [1:0] n;
    n = 2'd0;
    if (src != '0) begin
      if (ex_regwrite && (ex_rd == src)) begin
        n = ex_memread ? 2'd2 : 2'd1;
      end else if (exmem_regwrite && exmem_memread && (exmem_rd == src)) begin
        n = 2'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  logic       is_br;
  logic [1:0] need_rs, need_rt, need;

  assign is_br   = id_valid && (id_is_beq || id_is_bne);
  assign need_rs = src_need(id_rs);
  assign need_rt = src_need(id_rt);
  assign need    = is_br ? ((need_rs > need_rt) ? need_rs : need_rt) : 2'd0;

  state_e           state_q, state_d;
  logic [1:0]       scnt_q, scnt_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic             stall_raw, resolve, taken_raw;

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    stall_raw = 1'b0;
    resolve   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (need != 2'd0) begin
          stall_raw = 1'b1;
          scnt_d    = need - 2'd1;
          if (need != 2'd1) state_d = S_HOLD;
        end else begin
          resolve = is_br;
        end
      end
      S_HOLD: begin
        // A killed instruction no longer needs its operands, so release immediately.
        if (!id_valid) begin
          state_d = S_IDLE;
          scnt_d  = 2'd0;
        end else begin
          stall_raw = 1'b1;
          scnt_d    = scnt_q - 2'd1;
          if (scnt_q <= 2'd1) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        scnt_d  = 2'd0;
      end
    endcase
  end

  assign taken_raw    = resolve && (id_is_beq ? (op_a == op_b) : (op_a != op_b));
  assign cnt_branch_d = sat_inc(cnt_branch_q, resolve);
  assign cnt_taken_d  = sat_inc(cnt_taken_q, taken_raw);
  assign cnt_stall_d  = sat_inc(cnt_stall_q, stall_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      scnt_q       <= 2'd0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  // Outputs are gated by reset so a mid-stall reset drops them without waiting for a clock.
  assign stall        = rst_n && stall_raw;
  assign branch_taken = rst_n && taken_raw;
  assign if_flush     = branch_taken;
  assign fwd_sel_rs   = rst_n ? sel_rs : FWD_RF;
  assign fwd_sel_rt   = rst_n ? sel_rt : FWD_RF;
  assign cnt_branch   = cnt_branch_q;
  assign cnt_taken    = cnt_taken_q;
  assign cnt_stall    = cnt_stall_q;

endmodule
`default_nettype wire
